// File: rtl/pc_redirect_ctrl_if.sv
// Front-end redirect bus between the pipeline (master) and the next-PC controller (slave).
// Trap signals exist only when YSYX22040228_PC_TRAP_EN is defined.
interface pc_redirect_ctrl_if #(
  parameter int PC_W = 64
);
  logic [PC_W-1:0] seq_pc_i;
  logic            bp_taken_i;
  logic [PC_W-1:0] bp_pc_i;
  logic            id_redir_i;
  logic [PC_W-1:0] id_pc_i;
  logic            ex_redir_i;
  logic [PC_W-1:0] ex_pc_i;
`ifdef YSYX22040228_PC_TRAP_EN
  logic            trap_i;
  logic [PC_W-1:0] trap_pc_i;
`endif
  logic            stall_i;
  logic            br_issue_i;
  logic            br_resolve_i;
  logic [PC_W-1:0] pc_o;
  logic            pc_ld_o;
  logic [2:0]      pc_src_o;
  logic            flush_o;
  logic [1:0]      br_cnt_o;
  logic            bp_block_o;

  modport master (
`ifdef YSYX22040228_PC_TRAP_EN
    output trap_i, trap_pc_i,
`endif
    output seq_pc_i, bp_taken_i, bp_pc_i, id_redir_i, id_pc_i,
    output ex_redir_i, ex_pc_i, stall_i, br_issue_i, br_resolve_i,
    input  pc_o, pc_ld_o, pc_src_o, flush_o, br_cnt_o, bp_block_o
  );

  modport slave (
`ifdef YSYX22040228_PC_TRAP_EN
    input  trap_i, trap_pc_i,
`endif
    input  seq_pc_i, bp_taken_i, bp_pc_i, id_redir_i, id_pc_i,
    input  ex_redir_i, ex_pc_i, stall_i, br_issue_i, br_resolve_i,
    output pc_o, pc_ld_o, pc_src_o, flush_o, br_cnt_o, bp_block_o
  );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// Next-PC sequencing controller: source arbitration, stall-time redirect capture, flush and branch tracking.
// Optional trap source enabled by defining YSYX22040228_PC_TRAP_EN.
module pc_redirect_ctrl #(
  parameter int              PC_W      = 64,
  parameter logic [PC_W-1:0] START_PC  = PC_W'(64'h8000_0000),
  parameter int              FLUSH_CYC = 2
) (
  input logic               clk,
  input logic               rst,
  pc_redirect_ctrl_if.slave bus
);

  localparam logic [2:0] SRC_SEQ  = 3'd0;
  localparam logic [2:0] SRC_BP   = 3'd1;
  localparam logic [2:0] SRC_ID   = 3'd2;
  localparam logic [2:0] SRC_EX   = 3'd3;
  localparam logic [2:0] SRC_TRAP = 3'd4;
  localparam logic [2:0] SRC_RST  = 3'd7;
  localparam logic [2:0] FLUSH_LD = 3'(FLUSH_CYC);

  typedef enum logic [1:0] {
    ST_RESET,
    ST_RUN,
    ST_HOLD,
    ST_FLUSH
  } state_t;

  state_t          state;
  logic [PC_W-1:0] pc_q;
  logic            ld_q;
  logic [2:0]      src_q;
  logic            flush_q;
  logic [2:0]      fcnt;
  logic [1:0]      br_cnt;
  logic            bp_block;
  logic            pend_vld;
  logic [2:0]      pend_src;
  logic [PC_W-1:0] pend_pc;

  logic            trap_req;
  logic [PC_W-1:0] trap_tgt;
  logic            pulse_vld;
  logic [2:0]      pulse_src;
  logic [PC_W-1:0] pulse_pc;
  logic            pulse_redir;
  logic [2:0]      run_src;
  logic [PC_W-1:0] run_pc;
  logic            merge_vld;
  logic [2:0]      merge_src;
  logic [PC_W-1:0] merge_pc;
  logic [2:0]      hold_src;
  logic [PC_W-1:0] hold_pc;
  logic            redir_fire;
  logic [1:0]      br_cnt_nxt;

`ifdef YSYX22040228_PC_TRAP_EN
  assign trap_req = bus.trap_i;
  assign trap_tgt = bus.trap_pc_i;
`else
  assign trap_req = 1'b0;
  assign trap_tgt = '0;
`endif

  // Source codes are ordered so that a larger code always means higher priority.
  always_comb begin
    pulse_vld = 1'b1;
    pulse_src = SRC_TRAP;
    pulse_pc  = trap_tgt;
    if (trap_req) begin
      pulse_src = SRC_TRAP;
      pulse_pc  = trap_tgt;
    end else if (bus.ex_redir_i) begin
      pulse_src = SRC_EX;
      pulse_pc  = bus.ex_pc_i;
    end else if (bus.id_redir_i) begin
      pulse_src = SRC_ID;
      pulse_pc  = bus.id_pc_i;
    end else begin
      pulse_vld = 1'b0;
      pulse_src = SRC_SEQ;
      pulse_pc  = bus.seq_pc_i;
    end
  end

  assign pulse_redir = pulse_vld && (pulse_src >= SRC_EX);

  always_comb begin
    run_src = SRC_SEQ;
    run_pc  = bus.seq_pc_i;
    if (pulse_vld) begin
      run_src = pulse_src;
      run_pc  = pulse_pc;
    end else if (bus.bp_taken_i && !bp_block) begin
      run_src = SRC_BP;
      run_pc  = bus.bp_pc_i;
    end
  end

  always_comb begin
    merge_vld = pend_vld || pulse_vld;
    merge_src = pend_src;
    merge_pc  = pend_pc;
    if (pulse_vld && (!pend_vld || (pulse_src > pend_src))) begin
      merge_src = pulse_src;
      merge_pc  = pulse_pc;
    end
  end

  assign hold_src = merge_vld ? merge_src : run_src;
  assign hold_pc  = merge_vld ? merge_pc  : run_pc;

  always_comb begin
    redir_fire = 1'b0;
    case (state)
      ST_RUN:   redir_fire = !bus.stall_i && pulse_redir;
      ST_HOLD:  redir_fire = !bus.stall_i && (hold_src >= SRC_EX);
      ST_FLUSH: redir_fire = pulse_redir;
      default:  redir_fire = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RESET;
      pc_q     <= START_PC;
      ld_q     <= 1'b0;
      src_q    <= SRC_RST;
      flush_q  <= 1'b0;
      fcnt     <= '0;
      pend_vld <= 1'b0;
      pend_src <= SRC_SEQ;
      pend_pc  <= '0;
    end else begin
      ld_q <= 1'b0;
      case (state)
        ST_RESET: begin
          pc_q  <= START_PC;
          ld_q  <= 1'b1;
          src_q <= SRC_RST;
          state <= ST_RUN;
        end
        ST_RUN: begin
          if (bus.stall_i) begin
            state    <= ST_HOLD;
            pend_vld <= pulse_vld;
            pend_src <= pulse_src;
            pend_pc  <= pulse_pc;
          end else begin
            pc_q  <= run_pc;
            ld_q  <= 1'b1;
            src_q <= run_src;
            if (pulse_redir) begin
              state   <= ST_FLUSH;
              flush_q <= 1'b1;
              fcnt    <= FLUSH_LD;
            end
          end
        end
        ST_HOLD: begin
          if (bus.stall_i) begin
            pend_vld <= merge_vld;
            pend_src <= merge_src;
            pend_pc  <= merge_pc;
          end else begin
            pc_q     <= hold_pc;
            ld_q     <= 1'b1;
            src_q    <= hold_src;
            pend_vld <= 1'b0;
            if (redir_fire) begin
              state   <= ST_FLUSH;
              flush_q <= 1'b1;
              fcnt    <= FLUSH_LD;
            end else begin
              state <= ST_RUN;
            end
          end
        end
        ST_FLUSH: begin
          // Wrong-path id/bp requests are dropped; only a fresh ex/trap can redirect here.
          if (pulse_redir) begin
            pc_q  <= pulse_pc;
            ld_q  <= 1'b1;
            src_q <= pulse_src;
            fcnt  <= FLUSH_LD;
          end else if (fcnt <= 3'd1) begin
            pc_q    <= bus.seq_pc_i;
            ld_q    <= 1'b1;
            src_q   <= SRC_SEQ;
            flush_q <= 1'b0;
            state   <= ST_RUN;
          end else begin
            fcnt <= fcnt - 3'd1;
          end
        end
        default: state <= ST_RESET;
      endcase
    end
  end

  always_comb begin
    br_cnt_nxt = br_cnt;
    if (redir_fire) begin
      br_cnt_nxt = 2'd0;
    end else if (bus.br_issue_i && !bus.br_resolve_i && (br_cnt != 2'd3)) begin
      br_cnt_nxt = br_cnt + 2'd1;
    end else if (bus.br_resolve_i && !bus.br_issue_i && (br_cnt != 2'd0)) begin
      br_cnt_nxt = br_cnt - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt   <= 2'd0;
      bp_block <= 1'b0;
    end else begin
      br_cnt   <= br_cnt_nxt;
      bp_block <= (br_cnt_nxt == 2'd3);
    end
  end

  assign bus.pc_o       = pc_q;
  assign bus.pc_ld_o    = ld_q;
  assign bus.pc_src_o   = src_q;
  assign bus.flush_o    = flush_q;
  assign bus.br_cnt_o   = br_cnt;
  assign bus.bp_block_o = bp_block;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Scoreboard bench for pc_redirect_ctrl: directed scenarios then random traffic against a behavioural model.
module tb_pc_redirect_ctrl;

  localparam int          PC_W      = 64;
  localparam int          FLUSH_CYC = 2;
  localparam logic [63:0] START_PC  = 64'h8000_0000;

  typedef struct {
    logic [63:0] pc;
    bit          ld;
    logic [2:0]  src;
    bit          flush;
    logic [1:0]  cnt;
    bit          block;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pc_redirect_ctrl_if #(.PC_W(PC_W)) bus ();

  pc_redirect_ctrl #(
    .PC_W     (PC_W),
    .START_PC (START_PC),
    .FLUSH_CYC(FLUSH_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  bit          tr_req   = 1'b0;
  logic [63:0] tr_pc    = '0;

  // Model state: pending redirect kept as (priority, target); priority equals its source code.
  bit          m_boot       = 1'b1;
  int          m_flush_left = 0;
  int          m_pend_pri   = 0;
  logic [63:0] m_pend_pc    = '0;
  int          m_cnt        = 0;
  logic [63:0] m_pc         = START_PC;
  int          m_src        = 7;

  task automatic model_step(input bit r, input bit st, input bit bpt, input logic [63:0] bpc,
                            input bit idr, input logic [63:0] idpc, input bit exr,
                            input logic [63:0] expc, input bit tr, input logic [63:0] trpc,
                            input bit bi, input bit brs, input logic [63:0] seq,
                            output exp_t e);
    int          pri;
    logic [63:0] ppc;
    int          ipri;
    logic [63:0] ipc;
    bit          ld;
    bit          fire;
    pri  = 0;
    ppc  = '0;
    ld   = 1'b0;
    fire = 1'b0;
    if (idr) begin pri = 2; ppc = idpc; end
    if (exr) begin pri = 3; ppc = expc; end
    if (tr)  begin pri = 4; ppc = trpc; end
    if (r) begin
      m_boot = 1'b1; m_flush_left = 0; m_pend_pri = 0; m_cnt = 0;
      m_pc = START_PC; m_src = 7;
    end else if (m_boot) begin
      m_boot = 1'b0; m_pc = START_PC; m_src = 7; ld = 1'b1;
    end else if (m_flush_left > 0) begin
      if (pri >= 3) begin
        m_pc = ppc; m_src = pri; ld = 1'b1; fire = 1'b1; m_flush_left = FLUSH_CYC;
      end else if (m_flush_left == 1) begin
        m_pc = seq; m_src = 0; ld = 1'b1; m_flush_left = 0;
      end else begin
        m_flush_left--;
      end
    end else if (st) begin
      if (pri > m_pend_pri) begin m_pend_pri = pri; m_pend_pc = ppc; end
    end else begin
      if (pri > m_pend_pri) begin ipri = pri; ipc = ppc; end
      else begin ipri = m_pend_pri; ipc = m_pend_pc; end
      m_pend_pri = 0;
      ld = 1'b1;
      if (ipri > 0) begin m_pc = ipc; m_src = ipri; end
      else if (bpt && m_cnt < 3) begin m_pc = bpc; m_src = 1; end
      else begin m_pc = seq; m_src = 0; end
      if (ipri >= 3) begin m_flush_left = FLUSH_CYC; fire = 1'b1; end
    end
    if (!r) begin
      if (fire) m_cnt = 0;
      else if (bi && !brs && m_cnt < 3) m_cnt++;
      else if (brs && !bi && m_cnt > 0) m_cnt--;
    end
    e.pc    = m_pc;
    e.ld    = ld;
    e.src   = 3'(m_src);
    e.flush = (m_flush_left > 0);
    e.cnt   = 2'(m_cnt);
    e.block = (m_cnt == 3);
  endtask

  task automatic apply_stimulus(input bit r, input bit st, input bit bpt, input logic [63:0] bpc,
                                input bit idr, input logic [63:0] idpc, input bit exr,
                                input logic [63:0] expc, input bit bi, input bit brs);
    exp_t        e;
    logic [63:0] seq;
    @(negedge clk);
    seq              = {$urandom, $urandom};
    rst              = r;
    bus.seq_pc_i     = seq;
    bus.stall_i      = st;
    bus.bp_taken_i   = bpt;
    bus.bp_pc_i      = bpc;
    bus.id_redir_i   = idr;
    bus.id_pc_i      = idpc;
    bus.ex_redir_i   = exr;
    bus.ex_pc_i      = expc;
    bus.br_issue_i   = bi;
    bus.br_resolve_i = brs;
`ifdef YSYX22040228_PC_TRAP_EN
    bus.trap_i    = tr_req;
    bus.trap_pc_i = tr_pc;
`endif
    model_step(r, st, bpt, bpc, idr, idpc, exr, expc, tr_req, tr_pc, bi, brs, seq, e);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(0, 0, 0, '0, 0, '0, 0, '0, 0, 0);
  endtask

  task automatic check_field(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  task automatic check_output(input exp_t e);
    check_field("pc_o",       bus.pc_o,       e.pc);
    check_field("pc_ld_o",    64'(bus.pc_ld_o),    64'(e.ld));
    check_field("pc_src_o",   64'(bus.pc_src_o),   64'(e.src));
    check_field("flush_o",    64'(bus.flush_o),    64'(e.flush));
    check_field("br_cnt_o",   64'(bus.br_cnt_o),   64'(e.cnt));
    check_field("bp_block_o", 64'(bus.bp_block_o), 64'(e.block));
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_output(e);
      end
    end
  end

  initial begin
    bit r, st, bpt, idr, exr, bi, brs;
    int st_left;
    bus.seq_pc_i = '0; bus.stall_i = 0; bus.bp_taken_i = 0; bus.bp_pc_i = '0;
    bus.id_redir_i = 0; bus.id_pc_i = '0; bus.ex_redir_i = 0; bus.ex_pc_i = '0;
    bus.br_issue_i = 0; bus.br_resolve_i = 0;
`ifdef YSYX22040228_PC_TRAP_EN
    bus.trap_i = 0; bus.trap_pc_i = '0;
`endif
    $display("[TB] reset and sequential fetch");
    apply_stimulus(1, 0, 0, '0, 0, '0, 0, '0, 0, 0);
    apply_stimulus(1, 0, 0, '0, 0, '0, 0, '0, 0, 0);
    idle(4);

    $display("[TB] simultaneous ex/id/bp");
    apply_stimulus(0, 0, 1, 64'h300, 1, 64'h200, 1, 64'h100, 0, 0);
    for (int i = 0; i < 3; i++) apply_stimulus(0, 0, 1, 64'h300, 1, 64'h200, 0, '0, 0, 0);
    idle(2);

    $display("[TB] stall capture");
    apply_stimulus(0, 1, 0, '0, 1, 64'h40, 0, '0, 0, 0);
    apply_stimulus(0, 1, 0, '0, 0, '0, 1, 64'h80, 0, 0);
    apply_stimulus(0, 1, 0, '0, 1, 64'hC0, 0, '0, 0, 0);
    apply_stimulus(0, 1, 0, '0, 0, '0, 0, '0, 0, 0);
    idle(4);

    $display("[TB] branch counter");
    for (int i = 0; i < 4; i++) apply_stimulus(0, 0, 0, '0, 0, '0, 0, '0, 1, 0);
    apply_stimulus(0, 0, 1, 64'h500, 0, '0, 0, '0, 0, 0);
    apply_stimulus(0, 0, 1, 64'h500, 0, '0, 0, '0, 1, 1);
    apply_stimulus(0, 0, 0, '0, 0, '0, 1, 64'h600, 1, 0);
    idle(3);

    $display("[TB] flush extension");
    apply_stimulus(0, 0, 0, '0, 0, '0, 1, 64'h700, 0, 0);
    apply_stimulus(0, 0, 0, '0, 0, '0, 1, 64'h740, 0, 0);
    idle(4);

`ifdef YSYX22040228_PC_TRAP_EN
    $display("[TB] trap over ex");
    tr_req = 1; tr_pc = 64'h1C0;
    apply_stimulus(0, 0, 0, '0, 0, '0, 1, 64'h900, 0, 0);
    tr_req = 0;
    idle(4);
`endif

    $display("[TB] random traffic");
    st_left = 0;
    for (int i = 0; i < 1500; i++) begin
      r = ($urandom_range(0, 199) == 0);
      if (st_left > 0) begin
        st = 1; st_left--;
      end else begin
        st = 0;
        if ($urandom_range(0, 9) == 0) st_left = $urandom_range(1, 5);
      end
      bpt = $urandom_range(0, 1) == 1;
      idr = ($urandom_range(0, 6) == 0);
      exr = ($urandom_range(0, 11) == 0);
      bi  = ($urandom_range(0, 2) == 0);
      brs = ($urandom_range(0, 3) == 0);
`ifdef YSYX22040228_PC_TRAP_EN
      tr_req = ($urandom_range(0, 29) == 0);
      tr_pc  = {$urandom, $urandom};
`endif
      apply_stimulus(r, st, bpt, {$urandom, $urandom}, idr, {$urandom, $urandom},
                     exr, {$urandom, $urandom}, bi, brs);
    end
    tr_req = 0;
    idle(3);

    repeat (2) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
